// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and constants for the push-button debouncer.
package key_debounce_pkg;

    // Per-channel debounce state: two idle states and two counting states.
    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        DISARMING = 2'd3
    } db_state_t;

    // Threshold used instead of STABLE_CYCLES in fast-simulation builds.
    localparam int DB_FAST_SIM_CYCLES = 4;

    // 10 ms at 50 MHz.
    localparam int DB_STABLE_CYCLES = 500000;

endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel.
// The channel is a two-flop synchroniser, a polarity normaliser and a
// stability-count FSM that produces a debounced level and a press pulse.
// Optional macro KEY_DEBOUNCE_FAST_SIM_EN: when defined, the acceptance
// threshold is DB_FAST_SIM_CYCLES. The counter is still sized from
// STABLE_CYCLES.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef KEY_DEBOUNCE_FAST_SIM_EN
    localparam int THRESH = DB_FAST_SIM_CYCLES;
`else
    localparam int THRESH = STABLE_CYCLES;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Pin level of a key that is not pressed.
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            p;
    db_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    // Synchroniser shift and polarity normalisation (p = 1 means pressed).
    always_comb begin
        s1_d = key_raw;
        s2_d = s1_q;
        p    = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
    end

    // Debounce FSM: a change is accepted after THRESH consecutive agreeing samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (p) begin
                    state_d = ARMING;
                    cnt_d   = CNT_ONE;
                end
            end
            ARMING: begin
                if (!p) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!p) begin
                    state_d = DISARMING;
                    cnt_d   = CNT_ONE;
                end
            end
            DISARMING: begin
                if (p) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // All channel state; reset puts the synchroniser at the idle pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= IDLE_PIN;
            s2_q    <= IDLE_PIN;
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign key_level = level_q;
    assign key_press = press_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: WIDTH independent key channels. Each one gives a clean
// debounced level and a one-cycle press pulse.
// Optional macro KEY_DEBOUNCE_FAST_SIM_EN shortens the threshold to
// DB_FAST_SIM_CYCLES for simulation. It is handled in key_debounce_chan.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_raw   (key_raw[i]),
            .key_level (key_level[i]),
            .key_press (key_press[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with STABLE_CYCLES=8,
// ACTIVE_LOW=1 and WIDTH=4. A run-length model is compared on every cycle,
// and literal expectations pin the model.
module tb_key_debounce;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_level;
    logic [W-1:0] key_press;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    key_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (N),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (key_raw),
        .key_level (key_level),
        .key_press (key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Behavioural model. A pin is seen two edges after it is driven. The
    // level flips once N consecutive samples disagree with it. Only a flip
    // to pressed produces a pulse.
    logic [W-1:0] m_s1    = '1;
    logic [W-1:0] m_s2    = '1;
    logic [W-1:0] m_level = '0;
    logic [W-1:0] m_press = '0;
    int           m_run [W];

    initial for (int i = 0; i < W; i++) m_run[i] = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1    <= '1;
            m_s2    <= '1;
            m_level <= '0;
            m_press <= '0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                m_press[i] <= 1'b0;
                if ((!m_s2[i]) != m_level[i]) begin
                    if (m_run[i] + 1 >= N) begin
                        m_level[i] <= !m_level[i];
                        m_press[i] <= !m_level[i];
                        m_run[i]   <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_s2 <= m_s1;
            m_s1 <= key_raw;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_level", key_level, m_level);
            chk("model_press", key_press, m_press);
        end
    end

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        key_raw = 4'hF;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;

        // Reset state through 20 cycles after release.
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            edge1();
            chk("rst_level", key_level, 4'b0000);
            chk("rst_press", key_press, 4'b0000);
        end

        // Clean press on channel 0.
        @(negedge clk);
        key_raw[0] = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            edge1();
            if (e == 8) chk("press_e8_level", key_level, 4'b0000);
            if (e == 9) begin
                chk("press_e9_level", key_level, 4'b0001);
                chk("press_e9_pulse", key_press, 4'b0001);
            end
            if (e == 10) begin
                chk("press_e10_level", key_level, 4'b0001);
                chk("press_e10_pulse", key_press, 4'b0000);
            end
        end

        // Bounce on channel 1: toggle every 3 cycles, then settle released.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            key_raw[1] = ((k / 3) % 2) != 0;
            edge1();
            chk("bounce_level1", {3'b000, key_level[1]}, 4'b0000);
            chk("bounce_press1", {3'b000, key_press[1]}, 4'b0000);
        end
        @(negedge clk);
        key_raw[1] = 1'b1;
        repeat (12) edge1();
        chk("bounce_settle", key_level, 4'b0001);

        // Release glitch of 5 cycles on channel 0 is rejected.
        @(negedge clk);
        key_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        key_raw[0] = 1'b0;
        repeat (15) edge1();
        chk("glitch_level", key_level, 4'b0001);

        // Real release on channel 0: no pulse.
        @(negedge clk);
        key_raw[0] = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            edge1();
            chk("release_no_pulse", key_press, 4'b0000);
            if (e == 8) chk("release_e8_level", key_level, 4'b0001);
            if (e == 9) chk("release_e9_level", key_level, 4'b0000);
        end

        // Simultaneous press on channels 2 and 3.
        @(negedge clk);
        key_raw[3:2] = 2'b00;
        for (int e = 0; e <= 10; e++) begin
            edge1();
            if (e == 8) chk("simul_e8_level", key_level, 4'b0000);
            if (e == 9) begin
                chk("simul_e9_level", key_level, 4'b1100);
                chk("simul_e9_pulse", key_press, 4'b1100);
            end
            if (e == 10) chk("simul_e10_pulse", key_press, 4'b0000);
        end

        // Reset during ARMING of channel 0, with channels 2 and 3 held.
        @(negedge clk);
        key_raw[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", key_level, 4'b0000);
        chk("async_rst_press", key_press, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            edge1();
            if (e == 8) chk("rst1_e8_level", key_level, 4'b0000);
            if (e == 9) begin
                chk("rst1_e9_level", key_level, 4'b1101);
                chk("rst1_e9_pulse", key_press, 4'b1101);
            end
            if (e == 10) chk("rst1_e10_pulse", key_press, 4'b0000);
        end

        // Reset while HELD.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("held_rst_level", key_level, 4'b0000);
        chk("held_rst_press", key_press, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            edge1();
            if (e == 8) chk("rst2_e8_level", key_level, 4'b0000);
            if (e == 9) begin
                chk("rst2_e9_level", key_level, 4'b1101);
                chk("rst2_e9_pulse", key_press, 4'b1101);
            end
            if (e == 10) chk("rst2_e10_pulse", key_press, 4'b0000);
        end

        // Release everything.
        @(negedge clk);
        key_raw = 4'hF;
        repeat (15) edge1();
        chk("final_level", key_level, 4'b0000);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-channel push-button conditioner that sits directly upstream of the one-shot button synchroniser. Each raw board key (DE1-SoC KEY, active-low) passes through a two-flop synchroniser and a stability counter, giving a clean debounced level plus a single-cycle press pulse. The edge-to-pulse stage then consumes a level that has no bounce and no metastability risk.

## Interface
- `WIDTH`, 4: number of independent key channels.
- `STABLE_CYCLES`, 500000: consecutive synchronised cycles needed to accept a change (10 ms at 50 MHz). Must be ≥ 2.
- `ACTIVE_LOW`, 1: when 1, raw input 0 means pressed. When 0, raw input 1 means pressed.

- `clk`  in  1: system clock; every flop is on its rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `key_raw`  in  WIDTH: asynchronous raw key pins.
- `key_level`  out  WIDTH: debounced level, 1 = pressed.
- `key_press`  out  WIDTH: one-cycle pulse on each accepted press.

## Operation
- Channels are fully independent. Channel i uses `key_raw[i]` only.
- Synchroniser: s1 <= raw, s2 <= s1. The polarity is normalised after s2: p = ACTIVE_LOW ? ~s2 : s2.
- Per-channel FSM states:
  - RELEASED: level 0.
  - ARMING: level 0, counting toward a press.
  - HELD: level 1.
  - DISARMING: level 1, counting toward a release.
- Transitions:
  - RELEASED → ARMING when p=1. The counter loads 1.
  - ARMING, p=0 → RELEASED. The counter clears; this is a bounce.
  - ARMING, p=1 and cnt == STABLE_CYCLES-1 → HELD. `key_press` is asserted for the next cycle.
  - ARMING, otherwise: cnt+1.
  - HELD → DISARMING when p=0. The counter loads 1.
  - DISARMING, p=1 → HELD. The counter clears.
  - DISARMING, p=0 and cnt == STABLE_CYCLES-1 → RELEASED. No pulse is generated.
  - DISARMING, otherwise: cnt+1.
- Counter width is $clog2(STABLE_CYCLES+1). It never wraps, because it is always cleared or compared before it can overflow.
- `key_level` and `key_press` are registered outputs. `key_press` is never high for two consecutive cycles.
- Reset values:
  - s1 and s2 reset to the inactive pin level (1 when ACTIVE_LOW).
  - State resets to RELEASED, cnt to 0, `key_level` to 0, `key_press` to 0.
- Reset during counting or while HELD: all outputs drop to 0 immediately (asynchronous).
  - A key still held when `rst_n` releases is accepted as a press after the full latency, and produces a pulse.

## Timing
- Latency: a clean raw change stable before edge 0 is reflected in `key_level` after edge STABLE_CYCLES+1. `key_press` rises on that same edge and falls one edge later.
- A glitch shorter than STABLE_CYCLES synchronised cycles never changes `key_level`.
- Any single-cycle reversal of p during counting restarts the count from 0.
- Raw changes closer together than two clocks may be lost in the synchroniser. This is accepted behaviour.

## Configuration
- `KEY_DEBOUNCE_FAST_SIM_EN` defined: the effective threshold is fixed at 4 cycles whatever `STABLE_CYCLES` is, for short simulations.
  - Latency becomes 5 edges.
  - The counter is still sized from `STABLE_CYCLES`.
- Not defined: `STABLE_CYCLES` is used as given. This is the synthesis default.

## Structure
- `key_debounce_pkg` holds:
  - the 2-bit FSM state enum `db_state_t` (RELEASED, ARMING, HELD, DISARMING);
  - the constant `DB_FAST_SIM_CYCLES = 4`;
  - the default `DB_STABLE_CYCLES = 500000`.
- One sub-module, `key_debounce_chan`, contains the synchroniser, counter and FSM for a single channel. The top level generates WIDTH instances of it.

## Test plan
Bench overrides: STABLE_CYCLES=8, ACTIVE_LOW=1, WIDTH=4.
- Reset: hold `rst_n`=0 with `key_raw`=4'hF, then release → `key_level`=0 and `key_press`=0 through 20 cycles.
- Clean press: drive `key_raw[0]`=0 before edge 0 and hold it → `key_level[0]`=1 after edge 9. `key_press[0]` is high for exactly one cycle, edge 9 to edge 10. Other channels stay 0.
- Bounce: toggle `key_raw[1]` 0/1 every 3 cycles for 40 cycles, then hold it at 1 → `key_level[1]` and `key_press[1]` never assert.
- Release: from HELD, set `key_raw[0]`=1 → `key_level[0]`=0 after 9 edges, with no `key_press` pulse. A release glitch of 5 cycles leaves `key_level` at 1.
- Simultaneous: press channels 2 and 3 on the same edge → both levels and both pulses assert on the same edge, edge 9.
- Reset mid-operation: assert `rst_n`=0 at cycle 5 of ARMING, and again while HELD → outputs go to 0 with no clock edge. After reset release with the key still pressed, one pulse follows after 9 edges.
